// File: rtl/trig_link_framer.sv
// Trigger link framer: frames N_LINKS 56-bit cluster streams into four 16-bit words per crossing,
// each replicated N_COPIES times. Define TRIG_LINK_PRBS_EN to add the PRBS-7 payload test pattern.

module trig_link_lane (
  input  logic        clock_160,
  input  logic        reset_n,
  input  logic        emit_i,
  input  logic [1:0]  ph_i,
  input  logic [7:0]  hdr_i,
  input  logic [55:0] data_i,
  input  logic        prbs_sel_i,
  input  logic [15:0] prbs_word_i,
  output logic [15:0] tx_data_o,
  output logic [1:0]  tx_isk_o
);
  logic [15:0] data_d, data_q;
  logic [1:0]  isk_d, isk_q;

  always_comb begin
    data_d = 16'hBC50;
    isk_d  = 2'b10;
    if (emit_i) begin
      isk_d = 2'b00;
      case (ph_i)
        2'd0: begin
          data_d = {hdr_i, data_i[55:48]};
          isk_d  = 2'b10;
        end
        2'd1:    data_d = data_i[47:32];
        2'd2:    data_d = data_i[31:16];
        default: data_d = data_i[15:0];
      endcase
      if (prbs_sel_i) data_d = prbs_word_i;
    end
  end

  always_ff @(posedge clock_160 or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 16'hBC50;
      isk_q  <= 2'b10;
    end else begin
      data_q <= data_d;
      isk_q  <= isk_d;
    end
  end

  assign tx_data_o = data_q;
  assign tx_isk_o  = isk_q;
endmodule

module trig_link_framer #(
  parameter int N_LINKS    = 2,
  parameter int N_COPIES   = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic                            clock_160,
  input  logic                            reset_n,
  input  logic                            ready_i,
  input  logic                            bx_strobe_i,
  input  logic [56*N_LINKS-1:0]           gem_data_i,
  input  logic                            overflow_i,
  input  logic                            bc0_i,
  input  logic                            resync_i,
  input  logic                            prbs_en_i,
  output logic [16*N_LINKS*N_COPIES-1:0]  tx_data_o,
  output logic [2*N_LINKS*N_COPIES-1:0]   tx_isk_o,
  output logic                            locked_o,
  output logic [7:0]                      misalign_cnt_o
);
  localparam int NTX = N_LINKS * N_COPIES;
  localparam logic [7:0] MISS_LIM = 8'(MISS_LIMIT);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               ph_q, ph_d;
  logic [7:0]               hdr_q, hdr_d;
  logic [7:0]               mis_q, mis_d;
  logic [7:0]               miss_q, miss_d;
  logic [N_LINKS-1:0][55:0] data_q, data_d;
  logic [7:0]               cap_hdr;
  logic                     strobe, emit;
  logic                     prbs_sel;
  logic [15:0]              prbs_word;
  logic [N_LINKS-1:0][15:0] lane_data;
  logic [N_LINKS-1:0][1:0]  lane_isk;

  assign strobe = bx_strobe_i && ready_i;
  assign emit   = (state_q == ST_LOCKED) && ready_i;

  // ph_q is the index of the word the output registers load on the next edge;
  // an aligned strobe lands exactly when ph_q wraps from 3.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + 2'd1;
    hdr_d   = hdr_q;
    data_d  = data_q;
    mis_d   = mis_q;
    miss_d  = miss_q;
    if (resync_i)        cap_hdr = 8'h1C;
    else if (bc0_i)      cap_hdr = 8'h7C;
    else if (overflow_i) cap_hdr = 8'hF7;
    else                 cap_hdr = 8'hBC;
    case (state_q)
      ST_UNLOCKED: begin
        ph_d = 2'd0;
        if (strobe) begin
          state_d = ST_LOCKED;
          hdr_d   = cap_hdr;
          data_d  = gem_data_i;
          miss_d  = 8'd0;
        end
      end
      default: begin
        if (!ready_i) begin
          state_d = ST_UNLOCKED;
          ph_d    = 2'd0;
          miss_d  = 8'd0;
        end else if (strobe) begin
          ph_d   = 2'd0;
          hdr_d  = cap_hdr;
          data_d = gem_data_i;
          miss_d = 8'd0;
          if (ph_q != 2'd3 && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
        end else if (ph_q == 2'd3) begin
          // Missing strobe: still send a frame slot, with a plain header and no clusters.
          hdr_d  = 8'hBC;
          data_d = '0;
          if (miss_q + 8'd1 >= MISS_LIM) begin
            state_d = ST_UNLOCKED;
            miss_d  = 8'd0;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UNLOCKED;
      ph_q    <= 2'd0;
      hdr_q   <= 8'hBC;
      data_q  <= '0;
      mis_q   <= 8'd0;
      miss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      miss_q  <= miss_d;
    end
  end

`ifdef TRIG_LINK_PRBS_EN
  logic [6:0] prbs_q, prbs_d, prbs_s;

  // One 16-bit slice per payload word, first generated bit in the MSB.
  always_comb begin
    prbs_s    = prbs_q;
    prbs_word = '0;
    for (int b = 15; b >= 0; b--) begin
      prbs_word[b] = prbs_s[6] ^ prbs_s[5];
      prbs_s       = {prbs_s[5:0], prbs_word[b]};
    end
    prbs_sel = emit && prbs_en_i && (ph_q != 2'd0);
    prbs_d   = prbs_sel ? prbs_s : prbs_q;
  end

  always_ff @(posedge clock_160 or negedge reset_n) begin
    if (!reset_n) prbs_q <= 7'h7F;
    else          prbs_q <= prbs_d;
  end
`else
  logic unused_prbs_en;
  assign unused_prbs_en = prbs_en_i;
  assign prbs_sel       = 1'b0;
  assign prbs_word      = '0;
`endif

  for (genvar l = 0; l < N_LINKS; l++) begin : g_lane
    trig_link_lane u_lane (
      .clock_160   (clock_160),
      .reset_n     (reset_n),
      .emit_i      (emit),
      .ph_i        (ph_q),
      .hdr_i       (hdr_q),
      .data_i      (data_q[l]),
      .prbs_sel_i  (prbs_sel),
      .prbs_word_i (prbs_word),
      .tx_data_o   (lane_data[l]),
      .tx_isk_o    (lane_isk[l])
    );
  end

  for (genvar j = 0; j < NTX; j++) begin : g_copy
    assign tx_data_o[16*j +: 16] = lane_data[j % N_LINKS];
    assign tx_isk_o[2*j +: 2]    = lane_isk[j % N_LINKS];
  end

  assign locked_o       = (state_q == ST_LOCKED);
  assign misalign_cnt_o = mis_q;
endmodule

// File: tb/tb_trig_link_framer.sv
// Randomized bench for trig_link_framer against a frame-slot timeline model; PRBS checks under TRIG_LINK_PRBS_EN.
module tb_trig_link_framer;
  localparam int NL = 3, NC = 2, NTX = NL * NC, ML = 2;

  logic clk = 1'b0, rst_n = 1'b1, ready = 1'b0, strobe = 1'b0;
  logic ovf = 1'b0, bc0 = 1'b0, rsy = 1'b0, pen = 1'b0;
  logic [56*NL-1:0]  gdata = '0;
  logic [16*NTX-1:0] tx_data;
  logic [2*NTX-1:0]  tx_isk;
  logic              locked;
  logic [7:0]        mis;

  trig_link_framer #(.N_LINKS(NL), .N_COPIES(NC), .MISS_LIMIT(ML)) dut (
    .clock_160(clk), .reset_n(rst_n), .ready_i(ready), .bx_strobe_i(strobe),
    .gem_data_i(gdata), .overflow_i(ovf), .bc0_i(bc0), .resync_i(rsy), .prbs_en_i(pen),
    .tx_data_o(tx_data), .tx_isk_o(tx_isk), .locked_o(locked), .misalign_cnt_o(mis)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  // Timeline model: expected word per displayed cycle, keyed by cycle number; absent = idle.
  typedef logic [NL-1:0][15:0] wv_t;
  wv_t        sw [int];
  logic [1:0] sk [int];
  bit         spl [int];
  bit         m_locked;
  int         m_next, m_miss, m_mis, sp_ptr;
  bit         seq [127];
  logic [16*NTX-1:0] e_data;
  logic [2*NTX-1:0]  e_isk;
  logic              e_lock;
  logic [7:0]        e_mis;

  function automatic logic [7:0] hdr_of();
    return rsy ? 8'h1C : bc0 ? 8'h7C : ovf ? 8'hF7 : 8'hBC;
  endfunction

  task automatic mreset();
    sw.delete(); sk.delete(); spl.delete();
    m_locked = 0; m_miss = 0; m_mis = 0; sp_ptr = 0;
  endtask

  task automatic sched(input int c, input logic [7:0] h, input logic [56*NL-1:0] d);
    wv_t w;
    logic [55:0] x;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < NL; l++) begin
        x = d[56*l +: 56];
        w[l] = (k == 0) ? {h, x[55:48]} : 16'(x >> (16 * (3 - k)));
      end
      sw[c+2+k] = w; sk[c+2+k] = (k == 0) ? 2'b10 : 2'b00; spl[c+2+k] = (k != 0);
    end
  endtask

  task automatic clr(input int c);
    for (int k = c + 1; k <= c + 6; k++) begin
      sw.delete(k); sk.delete(k); spl.delete(k);
    end
  endtask

  task automatic rnd_data();
    for (int l = 0; l < NL; l++) gdata[56*l +: 56] = 56'({$urandom(), $urandom()});
  endtask

  // Advance one clock: apply the frame-slot rules to this cycle's inputs, then form expectations.
  task automatic tick();
    int c;
    bit use_prbs;
    wv_t w;
    logic [15:0] pw;
    logic [1:0] k;
    c = cyc;
    if (!m_locked) begin
      if (ready && strobe) begin
        m_locked = 1; sched(c, hdr_of(), gdata); m_next = c + 4; m_miss = 0;
      end
    end else if (!ready) begin
      m_locked = 0; clr(c); m_miss = 0;
    end else if (strobe) begin
      if (c != m_next) m_mis = (m_mis == 255) ? 255 : m_mis + 1;
      sched(c, hdr_of(), gdata); m_next = c + 4; m_miss = 0;
    end else if (c == m_next) begin
      sched(c, 8'hBC, '0); m_next = c + 4; m_miss++;
      if (m_miss >= ML) begin m_locked = 0; clr(c + 1); m_miss = 0; end
    end
`ifdef TRIG_LINK_PRBS_EN
    use_prbs = pen;
`else
    use_prbs = 0;
`endif
    @(posedge clk); #1; cyc++;
    if (sw.exists(cyc)) begin
      w = sw[cyc]; k = sk[cyc];
      if (spl[cyc] && use_prbs) begin
        for (int i = 0; i < 16; i++) pw[15-i] = seq[(sp_ptr + i) % 127];
        sp_ptr = (sp_ptr + 16) % 127;
        for (int l = 0; l < NL; l++) w[l] = pw;
      end
      sw.delete(cyc); sk.delete(cyc); spl.delete(cyc);
    end else begin
      for (int l = 0; l < NL; l++) w[l] = 16'hBC50;
      k = 2'b10;
    end
    for (int j = 0; j < NTX; j++) begin
      e_data[16*j +: 16] = w[j % NL];
      e_isk[2*j +: 2]    = k;
    end
    e_lock = m_locked;
    e_mis  = 8'(m_mis);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; strobe = 1'b1;
    #2;
    n_cmp++; if (tx_data !== {NTX{16'hBC50}}) begin n_fail++; $display("FAIL reset_data got %h exp %h", tx_data, {NTX{16'hBC50}}); end
    n_cmp++; if (tx_isk !== {NTX{2'b10}}) begin n_fail++; $display("FAIL reset_isk got %h exp %h", tx_isk, {NTX{2'b10}}); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_cmp++; if (mis !== 8'd0) begin n_fail++; $display("FAIL reset_mis got %0d exp 0", mis); end
    @(posedge clk); #1;
    n_cmp++; if ({tx_data, tx_isk, locked} !== {{NTX{16'hBC50}}, {NTX{2'b10}}, 1'b0}) begin
      n_fail++; $display("FAIL reset_hold got %h %h %b", tx_data, tx_isk, locked); end
    @(posedge clk); #2;
    strobe = 1'b0; rst_n = 1'b1;
    mreset();
  endtask

  task automatic test_basic();
    logic [15:0] ref0 [4];
    ref0 = '{16'hBC12, 16'h3456, 16'h789A, 16'hBCDE};
    ready = 1'b1; pen = 1'b0; {ovf, bc0, rsy} = 3'b000;
    for (int i = 0; i < 32; i++) begin
      strobe = (i % 4 == 0); rnd_data();
      if (strobe) gdata[55:0] = 56'h123456789ABCDE;
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL basic cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i >= 1) begin
        n_cmp++;
        if (tx_data[15:0] !== ref0[(i-1)%4] || tx_isk[1:0] !== (((i-1)%4 == 0) ? 2'b10 : 2'b00) || locked !== 1'b1) begin
          n_fail++; $display("FAIL basic_link0 i=%0d got %h/%b/%b exp %h", i, tx_data[15:0], tx_isk[1:0], locked, ref0[(i-1)%4]); end
      end
    end
  endtask

  task automatic test_headers();
    for (int i = 0; i < 48; i++) begin
      strobe = (i % 4 == 0); rnd_data();
      {bc0, rsy, ovf} = 3'($urandom_range(0, 7));
      if (i == 0) {bc0, rsy, ovf} = 3'b110;
      if (i == 4) {bc0, rsy, ovf} = 3'b001;
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL headers cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 1 || i == 5) begin
        n_cmp++;
        if (tx_data[15:8] !== ((i == 1) ? 8'h1C : 8'hF7) || tx_data[16*NL+8 +: 8] !== tx_data[15:8]) begin
          n_fail++; $display("FAIL hdr_prio i=%0d got %h exp %h", i, tx_data[15:8], (i == 1) ? 8'h1C : 8'hF7); end
      end
    end
    {bc0, rsy, ovf} = 3'b000;
  endtask

  task automatic test_misalign();
    int nxt;
    nxt = 0;
    for (int i = 0; i < 21; i++) begin
      strobe = (i == nxt); rnd_data();
      if (strobe) nxt = i + ((i == 8) ? 5 : 4);
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL misalign cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 14) begin
        n_cmp++; if (mis !== 8'd1 || locked !== 1'b1) begin
          n_fail++; $display("FAIL misalign_once got %0d/%b exp 1/1", mis, locked); end
      end
    end
    for (int i = 0; i < 1502; i++) begin
      strobe = (i % 5 == 0); rnd_data();
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL misalign_sat cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
    end
    n_cmp++; if (mis !== 8'd255 || locked !== 1'b1) begin
      n_fail++; $display("FAIL misalign_saturate got %0d/%b exp 255/1", mis, locked); end
  endtask

  task automatic test_miss_unlock();
    for (int i = 0; i < 24; i++) begin
      strobe = (i == 2 || i == 6 || i == 10); rnd_data();
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL miss cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 15) begin
        n_cmp++; if (tx_data[15:0] !== 16'hBC00 || tx_isk[1:0] !== 2'b10 || locked !== 1'b1) begin
          n_fail++; $display("FAIL miss_zero_frame got %h/%b/%b exp bc00/10/1", tx_data[15:0], tx_isk[1:0], locked); end
      end
      if (i == 19) begin
        n_cmp++; if (tx_data !== {NTX{16'hBC50}} || locked !== 1'b0) begin
          n_fail++; $display("FAIL miss_unlock got %h/%b exp idle/0", tx_data, locked); end
      end
    end
  endtask

  task automatic test_ready_drop();
    for (int i = 0; i < 26; i++) begin
      ready = !(i == 10 || i == 11);
      strobe = (i == 0 || i == 4 || i == 8 || i == 13 || i == 17 || i == 21); rnd_data();
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL ready cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 10) begin
        n_cmp++; if (tx_data !== {NTX{16'hBC50}} || tx_isk !== {NTX{2'b10}} || locked !== 1'b0) begin
          n_fail++; $display("FAIL ready_drop_idle got %h/%b exp idle/0", tx_data, locked); end
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_reset_resume();
    for (int i = 0; i < 8; i++) begin
      strobe = (i % 4 == 1); rnd_data();
      tick();
    end
    rst_n = 1'b0; #1;
    n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {{NTX{16'hBC50}}, {NTX{2'b10}}, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL midreset got %h %h %b %0d", tx_data, tx_isk, locked, mis); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1; mreset();
    for (int i = 0; i < 16; i++) begin
      strobe = (i == 6 || i == 10 || i == 14); rnd_data();
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL resume cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 5) begin
        n_cmp++; if (locked !== 1'b0 || tx_data !== {NTX{16'hBC50}}) begin
          n_fail++; $display("FAIL resume_unlocked got %b/%h exp 0/idle", locked, tx_data); end
      end
    end
  endtask

  task automatic test_random();
    int nxt, rdy_hold, r;
    int gaps [6];
    gaps = '{3, 5, 6, 8, 9, 12};
    nxt = 2; rdy_hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (rdy_hold > 0) rdy_hold--;
      else if ($urandom_range(0, 149) == 0) rdy_hold = $urandom_range(1, 3);
      ready = (rdy_hold == 0);
      if ($urandom_range(0, 49) == 0) pen = ~pen;
      strobe = (i == nxt);
      if (strobe) begin
        r = $urandom_range(0, 19);
        nxt = i + ((r < 14) ? 4 : gaps[r % 6]);
      end
      rnd_data();
      {bc0, rsy, ovf} = 3'($urandom_range(0, 7));
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL random cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
    end
    ready = 1'b1; pen = 1'b0; {bc0, rsy, ovf} = 3'b000;
  endtask

`ifdef TRIG_LINK_PRBS_EN
  task automatic test_prbs();
    logic [15:0] pw;
    for (int b = 0; b < 16; b++) pw[15-b] = seq[b];
    rst_n = 1'b0; #1;
    @(posedge clk); #2;
    rst_n = 1'b1; mreset();
    ready = 1'b1; pen = 1'b1;
    for (int i = 0; i < 40; i++) begin
      strobe = (i % 4 == 0); rnd_data();
      tick();
      n_cmp++; if ({tx_data, tx_isk, locked, mis} !== {e_data, e_isk, e_lock, e_mis}) begin
        n_fail++; $display("FAIL prbs cyc=%0d got %h exp %h", cyc, {tx_data, tx_isk, locked, mis}, {e_data, e_isk, e_lock, e_mis}); end
      if (i == 2) begin
        n_cmp++; if (tx_data[15:0] !== pw || tx_data[16*NL +: 16] !== pw || tx_isk[1:0] !== 2'b00) begin
          n_fail++; $display("FAIL prbs_first got %h exp %h", tx_data[15:0], pw); end
      end
    end
    pen = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reference PRBS-7 stream: b[n] = b[n-7] ^ b[n-6], with the seven bits before the stream all ones.
    for (int n = 0; n < 127; n++)
      seq[n] = ((n >= 7) ? seq[n-7] : 1'b1) ^ ((n >= 6) ? seq[n-6] : 1'b1);
    mreset();
    #1;
    test_reset();
    test_basic();
    test_headers();
    test_misalign();
    test_miss_unlock();
    test_ready_drop();
    test_reset_resume();
    test_random();
`ifdef TRIG_LINK_PRBS_EN
    test_prbs();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_link_framer.md
TRIG_LINK_FRAMER -- requirements
Module: trig_link_framer

Interface
REQ-001 Parameter N_LINKS, default 2: independent 56-bit cluster streams framed per bunch crossing.
REQ-002 Parameter N_COPIES, default 2: identical replicas of each link's output; total outputs NTX = N_LINKS*N_COPIES.
REQ-003 Parameter MISS_LIMIT, default 2: consecutive missing strobes that force unlock.
REQ-004 clock_160  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ready_i  in  1  transceiver startup done; level.
REQ-007 bx_strobe_i  in  1  one-cycle pulse marking the 40 MHz capture cycle, nominally every 4 clocks.
REQ-008 gem_data_i  in  56*N_LINKS  cluster data, link k at bits [56k+55:56k].
REQ-009 overflow_i  in  1  more than 8 clusters this crossing.
REQ-010 bc0_i, resync_i  in  1 each  TTC flags, sampled with the strobe.
REQ-011 prbs_en_i  in  1  test-pattern request (see Configuration).
REQ-012 tx_data_o  out  16*NTX  word per transceiver; output j carries link j mod N_LINKS.
REQ-013 tx_isk_o  out  2*NTX  K-character flags, bit 1 = upper byte.
REQ-014 locked_o  out  1  framer in LOCKED state.
REQ-015 misalign_cnt_o  out  8  saturating count of realignments.

Function
REQ-016 gem_data_i, overflow_i, bc0_i and resync_i shall be captured only in a cycle with bx_strobe_i=1 and ready_i=1.
REQ-017 A 2-bit word counter shall drive the frame: word0 at capture+2 cycles, word1..word3 on the following cycles.
REQ-018 word0 = {hdr, data[55:48]} with isk 2'b10; word1 = data[47:32]; word2 = data[31:16]; word3 = data[15:0]; words 1-3 use isk 2'b00.
REQ-019 hdr priority: resync 8'h1C (K28.0) > bc0 8'h7C (K28.3) > overflow 8'hF7 (K23.7) > normal 8'hBC (K28.5).
REQ-020 States: UNLOCKED and LOCKED; the reset state is UNLOCKED.
REQ-021 In UNLOCKED, every word of every output shall be 16'hBC50 with isk 2'b10.
REQ-022 UNLOCKED->LOCKED on the first strobe while ready_i=1; the first frame follows per REQ-017.
REQ-023 LOCKED->UNLOCKED when ready_i=0; the idle word shall appear on the next cycle and any partial frame is aborted.
REQ-024 LOCKED->UNLOCKED after MISS_LIMIT consecutive frame slots with no strobe at the expected counter phase.
REQ-025 A single missed strobe while LOCKED shall produce a frame with hdr 8'hBC and zero data, then remain LOCKED.
REQ-026 A strobe at an unexpected phase while LOCKED shall restart the counter from that strobe, discard the in-flight frame, and increment misalign_cnt_o, saturating at 255.
REQ-027 bc0_i and resync_i asserted together shall emit resync only.
REQ-028 All outputs shall be registered; there is no combinational path from input to output.

Reset
REQ-029 During reset_n=0: tx_data_o=16'hBC50 per output, tx_isk_o=2'b10 per output, locked_o=0, misalign_cnt_o=0, word counter=0, PRBS state=7'h7F.
REQ-030 Reset deassertion mid-stream shall resume in UNLOCKED and require a new strobe to lock.

Configuration
REQ-031 With macro TRIG_LINK_PRBS_EN defined, prbs_en_i=1 while LOCKED shall replace words 1-3 with successive 16-bit slices of a PRBS-7 (x^7+x^6+1) sequence, advancing 16 bits per word; word0 keeps hdr and isk 2'b10.
REQ-032 Without TRIG_LINK_PRBS_EN, prbs_en_i shall be ignored and no PRBS logic synthesised.

Verification
REQ-033 Reset, ready_i=1, strobe every 4 cycles, link0 data 56'h123456789ABCDE -> words BC12, 3456, 789A, BCDE, isk 10,00,00,00, starting at strobe+2; locked_o=1.
REQ-034 bc0_i=1 and resync_i=1 on the same strobe -> word0 upper byte 8'h1C; next crossing with overflow_i only -> 8'hF7.
REQ-035 Strobe gap of 5 cycles once -> misalign_cnt_o 0->1, counter realigned, locked_o stays 1; 300 such events -> saturates at 255.
REQ-036 Strobes stopped for 2 slots -> one BC-with-zero-data frame, then 16'hBC50 idle and locked_o=0; ready_i dropped mid-frame -> idle on the next cycle.
REQ-037 N_LINKS=3, N_COPIES=2 -> outputs 0..5 carry links 0,1,2,0,1,2 with identical copies; TRIG_LINK_PRBS_EN with prbs_en_i=1 -> words 1-3 match a reference PRBS-7 stream seeded 7'h7F.
